// File: rtl/enc_pkg.sv
// Shared types and constants for the encoder homing sequencer.
package enc_pkg;

    // Homing sequencer states
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SEEK    = 3'd1,
        BACKOFF = 3'd2,
        REFINE  = 3'd3,
        SETTLE  = 3'd4
    } state_e;

    // Fault causes reported on err_code
    localparam logic [1:0] ERR_ABORT    = 2'b00;
    localparam logic [1:0] ERR_SEEK_TMO = 2'b01;
    localparam logic [1:0] ERR_BACK_TMO = 2'b10;
    localparam logic [1:0] ERR_REF_TMO  = 2'b11;

    // Default width of the position counter
    localparam int ENC_CNT_W = 21;

endpackage

// File: rtl/enc_down_timer.sv
// Loadable down-counter with zero flag; holds at zero rather than wrapping.
module enc_down_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] val_i,
    input  logic         en_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Load has priority over decrement; decrement stops at zero
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Count register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/encoder_home_ctrl.sv
// Homing sequencer: coarse index seek, back-off, slow index re-approach,
// counter clear on the refined index edge, then settle before reporting done.
module encoder_home_ctrl
    import enc_pkg::*;
#(
    parameter int CNT_W       = ENC_CNT_W,
    parameter int TMO_W       = 27,
    parameter int TIMEOUT_CYC = 125000000,
    parameter int SETTLE_CYC  = 1250,
    parameter int BACKOFF_CNT = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             home_start,
    input  logic             abort,
    input  logic             seek_dir,
    input  logic             step_en,
    input  logic             step_dir,
    input  logic             z_idx,
    input  logic [CNT_W-1:0] position,
    output logic             cnt_clr,
    output logic             motor_run,
    output logic             motor_dir,
    output logic             motor_slow,
    output logic             busy,
    output logic             home_done,
    output logic             home_err,
    output logic [1:0]       err_code,
    output logic [CNT_W-1:0] z_pos
);

    localparam int BO_W = $clog2(BACKOFF_CNT + 1);
    localparam int ST_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    localparam logic [BO_W-1:0]  BO_MAX    = BO_W'(BACKOFF_CNT);
    localparam logic [TMO_W-1:0] WD_RELOAD = TMO_W'(TIMEOUT_CYC - 1);
    localparam logic [ST_W-1:0]  ST_RELOAD = ST_W'(SETTLE_CYC - 1);

    state_e           state_q, state_d;
    logic             run_q, run_d;
    logic             dir_q, dir_d;
    logic             slow_q, slow_d;
    logic             clr_q, clr_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [1:0]       code_q, code_d;
    logic [CNT_W-1:0] zpos_q, zpos_d;
    logic             dir_r_q, dir_r_d;
    logic             zdly_q;
    logic [BO_W-1:0]  bo_q, bo_d, bo_n;

    logic             wd_load, wd_zero;
    logic             st_load, st_zero, st_en;
    logic             z_rise;
    logic             fault;
    logic [1:0]       fault_code;

    // A level already high when we start looking is not an edge
    assign z_rise = z_idx & ~zdly_q;
    assign st_en  = (state_q == SETTLE);

    // Per-phase watchdog; only consulted in SEEK, BACKOFF and REFINE
    enc_down_timer #(.W(TMO_W)) u_watchdog (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (wd_load),
        .val_i  (WD_RELOAD),
        .en_i   (1'b1),
        .zero_o (wd_zero)
    );

    // Quiet-time timer after the counter clear
    enc_down_timer #(.W(ST_W)) u_settle (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (st_load),
        .val_i  (ST_RELOAD),
        .en_i   (st_en),
        .zero_o (st_zero)
    );

    // Next-state and registered-output logic; abort beats progress beats timeout
    always_comb begin
        state_d    = state_q;
        run_d      = run_q;
        dir_d      = dir_q;
        slow_d     = slow_q;
        clr_d      = 1'b0;
        done_d     = done_q;
        err_d      = err_q;
        code_d     = code_q;
        zpos_d     = zpos_q;
        dir_r_d    = dir_r_q;
        bo_d       = bo_q;
        bo_n       = bo_q;
        wd_load    = 1'b0;
        st_load    = 1'b0;
        fault      = 1'b0;
        fault_code = ERR_ABORT;

        if ((state_q != IDLE) && abort) begin
            fault = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (home_start && !abort) begin
                        dir_r_d = seek_dir;
                        done_d  = 1'b0;
                        err_d   = 1'b0;
                        code_d  = ERR_ABORT;
                        state_d = SEEK;
                        run_d   = 1'b1;
                        dir_d   = seek_dir;
                        slow_d  = 1'b0;
                        wd_load = 1'b1;
                    end
                end
                SEEK: begin
                    if (z_rise) begin
                        zpos_d  = position;
                        state_d = BACKOFF;
                        dir_d   = ~dir_r_q;
                        bo_d    = BO_MAX;
                        wd_load = 1'b1;
                    end else if (wd_zero) begin
                        fault      = 1'b1;
                        fault_code = ERR_SEEK_TMO;
                    end
                end
                BACKOFF: begin
                    // Steps away from the index count down; jitter back toward it counts up
                    if (step_en) begin
                        if (step_dir != dir_r_q) begin
                            bo_n = bo_q - 1'b1;
                        end else if (bo_q < BO_MAX) begin
                            bo_n = bo_q + 1'b1;
                        end
                    end
                    bo_d = bo_n;
                    if (bo_n == '0) begin
                        state_d = REFINE;
                        dir_d   = dir_r_q;
                        slow_d  = 1'b1;
                        wd_load = 1'b1;
                    end else if (wd_zero) begin
                        fault      = 1'b1;
                        fault_code = ERR_BACK_TMO;
                    end
                end
                REFINE: begin
                    if (z_rise) begin
                        clr_d   = 1'b1;
                        run_d   = 1'b0;
                        slow_d  = 1'b0;
                        state_d = SETTLE;
                        st_load = 1'b1;
                    end else if (wd_zero) begin
                        fault      = 1'b1;
                        fault_code = ERR_REF_TMO;
                    end
                end
                SETTLE: begin
                    // Any residual motion restarts the quiet window
                    if (step_en) begin
                        st_load = 1'b1;
                    end else if (st_zero) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        if (fault) begin
            state_d = IDLE;
            run_d   = 1'b0;
            slow_d  = 1'b0;
            clr_d   = 1'b0;
            err_d   = 1'b1;
            code_d  = fault_code;
            wd_load = 1'b0;
            st_load = 1'b0;
        end
    end

    // State and output registers; reset drops the motor immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            run_q   <= 1'b0;
            dir_q   <= 1'b0;
            slow_q  <= 1'b0;
            clr_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= 2'b00;
            zpos_q  <= '0;
            dir_r_q <= 1'b0;
            zdly_q  <= 1'b0;
            bo_q    <= '0;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
            dir_q   <= dir_d;
            slow_q  <= slow_d;
            clr_q   <= clr_d;
            done_q  <= done_d;
            err_q   <= err_d;
            code_q  <= code_d;
            zpos_q  <= zpos_d;
            dir_r_q <= dir_r_d;
            zdly_q  <= z_idx;
            bo_q    <= bo_d;
        end
    end

    assign cnt_clr    = clr_q;
    assign motor_run  = run_q;
    assign motor_dir  = dir_q;
    assign motor_slow = slow_q;
    assign busy       = (state_q != IDLE);
    assign home_done  = done_q;
    assign home_err   = err_q;
    assign err_code   = code_q;
    assign z_pos      = zpos_q;

endmodule

// File: tb/tb_encoder_home_ctrl.sv
// Directed bench for encoder_home_ctrl with short timing parameters.
module tb_encoder_home_ctrl;

    logic        clk;
    logic        rst_n;
    logic        home_start;
    logic        abort;
    logic        seek_dir;
    logic        step_en;
    logic        step_dir;
    logic        z_idx;
    logic [20:0] position;
    logic        cnt_clr;
    logic        motor_run;
    logic        motor_dir;
    logic        motor_slow;
    logic        busy;
    logic        home_done;
    logic        home_err;
    logic [1:0]  err_code;
    logic [20:0] z_pos;

    int n_pass;
    int n_total;
    int clr_cnt;
    int bo_seq [7];

    encoder_home_ctrl #(
        .CNT_W       (21),
        .TMO_W       (27),
        .TIMEOUT_CYC (1000),
        .SETTLE_CYC  (16),
        .BACKOFF_CNT (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .home_start (home_start),
        .abort      (abort),
        .seek_dir   (seek_dir),
        .step_en    (step_en),
        .step_dir   (step_dir),
        .z_idx      (z_idx),
        .position   (position),
        .cnt_clr    (cnt_clr),
        .motor_run  (motor_run),
        .motor_dir  (motor_dir),
        .motor_slow (motor_slow),
        .busy       (busy),
        .home_done  (home_done),
        .home_err   (home_err),
        .err_code   (err_code),
        .z_pos      (z_pos)
    );

    initial clk = 1'b0;
    always #4 clk = ~clk;

    // Count clear pulses independently of the directed sequence
    initial clr_cnt = 0;
    always @(negedge clk) begin
        if (cnt_clr === 1'b1) clr_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic start_pulse();
        home_start = 1'b1;
        tick();
        home_start = 1'b0;
    endtask

    task automatic step1(input logic d);
        step_en  = 1'b1;
        step_dir = d;
        tick();
        step_en  = 1'b0;
    endtask

    initial begin
        n_pass = 0;
        n_total = 0;
        rst_n = 1'b0; home_start = 1'b0; abort = 1'b0; seek_dir = 1'b0;
        step_en = 1'b0; step_dir = 1'b0; z_idx = 1'b0; position = '0;
        bo_seq = '{0, 1, 0, 1, 1, 1, 1};
        tick(); tick();

        // ---------------- reset state
        chk("rst_busy", busy, 0);
        chk("rst_run", motor_run, 0);
        chk("rst_dir", motor_dir, 0);
        chk("rst_slow", motor_slow, 0);
        chk("rst_done", home_done, 0);
        chk("rst_err", home_err, 0);
        chk("rst_code", err_code, 0);
        chk("rst_zpos", z_pos, 0);
        chk("rst_clr", cnt_clr, 0);
        rst_n = 1'b1;
        tick();

        // ---------------- nominal run, seek_dir = 0
        seek_dir = 1'b0;
        start_pulse();
        chk("nom_busy", busy, 1);
        chk("nom_run", motor_run, 1);
        chk("nom_dir_seek", motor_dir, 0);
        chk("nom_slow_seek", motor_slow, 0);
        for (int i = 1; i <= 20; i++) begin
            position = position - 21'd1;
            step1(1'b0);
            tick();
        end
        position = 21'h1FFFEC;
        z_idx = 1'b1;
        tick();
        z_idx = 1'b0;
        chk("nom_zpos", z_pos, 21'h1FFFEC);
        chk("nom_dir_back", motor_dir, 1);
        chk("nom_slow_back", motor_slow, 0);
        tick();
        for (int i = 1; i <= 4; i++) begin
            position = position + 21'd1;
            step1(1'b1);
            if (i == 3) chk("nom_bo_not_done", motor_slow, 0);
            if (i == 4) begin
                chk("nom_slow_ref", motor_slow, 1);
                chk("nom_dir_ref", motor_dir, 0);
            end
            tick();
        end
        tick();
        z_idx = 1'b1;
        tick();
        z_idx = 1'b0;
        chk("nom_clr", cnt_clr, 1);
        chk("nom_run_stop", motor_run, 0);
        chk("nom_slow_stop", motor_slow, 0);
        chk("nom_busy_settle", busy, 1);
        tick();
        chk("nom_clr_one", cnt_clr, 0);
        repeat (14) tick();
        chk("nom_done_early", home_done, 0);
        tick();
        chk("nom_done", home_done, 1);
        chk("nom_busy_end", busy, 0);
        chk("nom_err", home_err, 0);
        chk("nom_clr_count", clr_cnt, 1);

        // ---------------- seek timeout
        seek_dir = 1'b1;
        start_pulse();
        chk("tmo_done_cleared", home_done, 0);
        chk("tmo_dir", motor_dir, 1);
        repeat (999) tick();
        chk("tmo_err_early", home_err, 0);
        chk("tmo_busy_early", busy, 1);
        tick();
        chk("tmo_err", home_err, 1);
        chk("tmo_code", err_code, 2'b01);
        chk("tmo_run", motor_run, 0);
        chk("tmo_busy", busy, 0);

        // ---------------- back-off jitter, then abort in REFINE
        seek_dir = 1'b0;
        start_pulse();
        chk("jit_err_cleared", home_err, 0);
        chk("jit_code_cleared", err_code, 0);
        tick();
        z_idx = 1'b1;
        tick();
        z_idx = 1'b0;
        chk("jit_dir_back", motor_dir, 1);
        tick();
        // count: 4 (sat), 3, 4, 3, 2, 1, 0
        for (int i = 0; i < 7; i++) begin
            step1(bo_seq[i] != 0);
            if (i < 6) chk($sformatf("jit_slow_%0d", i), motor_slow, 0);
            if (i == 2) begin
                z_idx = 1'b1;
                tick();
                z_idx = 1'b0;
                tick();
                chk("jit_z_ignored_slow", motor_slow, 0);
                chk("jit_z_ignored_dir", motor_dir, 1);
                chk("jit_z_ignored_clr", clr_cnt, 1);
            end
            if (i == 6) begin
                chk("jit_refine_slow", motor_slow, 1);
                chk("jit_refine_dir", motor_dir, 0);
            end
            if (i < 6) tick();
        end
        repeat (999) tick();
        chk("abt_busy_before", busy, 1);
        chk("abt_err_before", home_err, 0);
        abort = 1'b1;
        z_idx = 1'b1;
        tick();
        abort = 1'b0;
        z_idx = 1'b0;
        chk("abt_code", err_code, 2'b00);
        chk("abt_err", home_err, 1);
        chk("abt_clr", cnt_clr, 0);
        chk("abt_done", home_done, 0);
        chk("abt_run", motor_run, 0);
        chk("abt_slow", motor_slow, 0);
        chk("abt_busy", busy, 0);
        tick(); tick();
        chk("abt_clr_count", clr_cnt, 1);

        // ---------------- settle restart, seek_dir = 1
        seek_dir = 1'b1;
        start_pulse();
        chk("set_err_cleared", home_err, 0);
        tick();
        position = 21'h000123;
        z_idx = 1'b1;
        tick();
        z_idx = 1'b0;
        chk("set_zpos", z_pos, 21'h000123);
        chk("set_dir_back", motor_dir, 0);
        tick();
        for (int i = 0; i < 4; i++) begin
            step1(1'b0);
            if (i == 3) begin
                chk("set_slow_ref", motor_slow, 1);
                chk("set_dir_ref", motor_dir, 1);
            end else begin
                tick();
            end
        end
        tick(); tick();
        z_idx = 1'b1;
        tick();
        z_idx = 1'b0;
        chk("set_clr", cnt_clr, 1);
        repeat (12) tick();
        step1(1'b1);
        repeat (3) tick();
        chk("set_done_restarted", home_done, 0);
        repeat (12) tick();
        chk("set_done_early", home_done, 0);
        chk("set_busy_early", busy, 1);
        tick();
        chk("set_done", home_done, 1);
        chk("set_busy_end", busy, 0);
        chk("set_clr_count", clr_cnt, 2);

        // ---------------- start while busy, then async reset mid-BACKOFF
        seek_dir = 1'b0;
        start_pulse();
        chk("rb_done_cleared", home_done, 0);
        chk("rb_dir", motor_dir, 0);
        tick(); tick();
        seek_dir = 1'b1;
        home_start = 1'b1;
        tick();
        home_start = 1'b0;
        chk("rb_second_start_dir", motor_dir, 0);
        chk("rb_second_start_busy", busy, 1);
        position = 21'h0ABCDE;
        z_idx = 1'b1;
        tick();
        z_idx = 1'b0;
        chk("rb_zpos", z_pos, 21'h0ABCDE);
        chk("rb_dir_back", motor_dir, 1);
        tick();
        step1(1'b1);
        chk("rb_run_before", motor_run, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rb_run_async", motor_run, 0);
        chk("rb_busy_async", busy, 0);
        chk("rb_dir_async", motor_dir, 0);
        chk("rb_slow_async", motor_slow, 0);
        chk("rb_zpos_async", z_pos, 0);
        chk("rb_done_async", home_done, 0);
        chk("rb_err_async", home_err, 0);
        chk("rb_code_async", err_code, 0);
        chk("rb_clr_async", cnt_clr, 0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("rb_idle_busy", busy, 0);
        chk("rb_idle_run", motor_run, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
